// File: rtl/max7219_pkg.sv
// -----------------------------------------------------------------------------
// max7219_pkg
// Shared definitions for the MAX7219 daisy-chain transmitter.
//   - MAX7219 register address map
//   - WORD_W       : bits per device command word (address byte + data byte)
//   - tx_state_e   : transmitter state encoding {ST_GAP, ST_SHIFT}
//   - make_word()  : packs one device's address/data bytes into a command word
// No ports (package).
// -----------------------------------------------------------------------------
package max7219_pkg;

    localparam int WORD_W = 16;

    // MAX7219 register map
    localparam logic [7:0] REG_NOOP         = 8'h00;
    localparam logic [7:0] REG_DIGIT0       = 8'h01;
    localparam logic [7:0] REG_DIGIT1       = 8'h02;
    localparam logic [7:0] REG_DIGIT2       = 8'h03;
    localparam logic [7:0] REG_DIGIT3       = 8'h04;
    localparam logic [7:0] REG_DIGIT4       = 8'h05;
    localparam logic [7:0] REG_DIGIT5       = 8'h06;
    localparam logic [7:0] REG_DIGIT6       = 8'h07;
    localparam logic [7:0] REG_DIGIT7       = 8'h08;
    localparam logic [7:0] REG_DECODE_MODE  = 8'h09;
    localparam logic [7:0] REG_INTENSITY    = 8'h0A;
    localparam logic [7:0] REG_SCAN_LIMIT   = 8'h0B;
    localparam logic [7:0] REG_SHUTDOWN     = 8'h0C;
    localparam logic [7:0] REG_DISPLAY_TEST = 8'h0F;

    typedef enum logic [0:0] {
        ST_GAP   = 1'b0,
        ST_SHIFT = 1'b1
    } tx_state_e;

    // The MAX7219 expects the address byte first, then the data byte.
    function automatic logic [WORD_W-1:0] make_word(input logic [7:0] addr,
                                                    input logic [7:0] dat);
        return {addr, dat};
    endfunction

endpackage

// File: rtl/max7219_sclk_gen.sv
// -----------------------------------------------------------------------------
// max7219_sclk_gen
// CLK_DIV phase counter producing the serial clock for the MAX7219 chain.
// While enabled, sclk is low for CLK_DIV cycles then high for CLK_DIV cycles.
// While disabled, the counter is cleared and sclk is held low, so every
// enable starts with a full low phase.
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous reset, active-high
//   en_i    in   run the divider (transmitter is shifting)
//   sclk_o  out  registered serial clock, idle low
//   fall_o  out  strobe: the coming clk edge ends the high phase (sclk falls)
// -----------------------------------------------------------------------------
module max7219_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output logic sclk_o,
    output logic fall_o
);

    localparam int               DIV_W    = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             sclk_q;
    logic             sclk_d;
    logic             phase_end_s;

    assign phase_end_s = en_i && (div_q == DIV_LAST);
    assign fall_o      = phase_end_s && sclk_q;
    assign sclk_o      = sclk_q;

    // Next-state for the phase counter and the sclk level.
    always_comb begin
        div_d  = div_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            div_d  = '0;
            sclk_d = 1'b0;
        end else if (phase_end_s) begin
            div_d  = '0;
            sclk_d = !sclk_q;
        end else begin
            div_d  = div_q + DIV_W'(1);
            sclk_d = sclk_q;
        end
    end

    // Phase counter and sclk registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/max7219_chain_tx.sv
// -----------------------------------------------------------------------------
// max7219_chain_tx
// Serial transmitter for a daisy-chain of SIZE MAX7219 drivers. Each frame
// carries one 16-bit word per device inside a single cs-low window, MSB first,
// farthest device (SIZE-1) first. cs rising latches all devices at once.
// Frame period is 32*SIZE*CLK_DIV + CS_GAP clk cycles.
//
// Optional build macro: MAX7219_TX_SKIP_REPEAT_EN
//   When defined, a frame whose address/data equal the last transmitted frame
//   is not sent; finished is still pulsed and the gap restarts, giving a
//   CS_GAP+1 cycle period. The first frame after reset is always sent.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous reset, active-high
//   address   in   [8*SIZE] register address, slice [8k+7:8k] -> device k
//   data      in   [8*SIZE] register data, same slicing
//   mosi      out  serial data to DIN of device 0
//   sclk      out  serial clock, idle low (devices sample on its rising edge)
//   cs        out  LOAD/CS, active-low
//   finished  out  one-cycle pulse in the first cycle of each gap
// -----------------------------------------------------------------------------
module max7219_chain_tx
    import max7219_pkg::*;
#(
    parameter int SIZE    = 2,
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [8*SIZE-1:0] address,
    input  logic [8*SIZE-1:0] data,
    output logic              mosi,
    output logic              sclk,
    output logic              cs,
    output logic              finished
);

    localparam int FRAME_W = WORD_W * SIZE;
    localparam int BIT_W   = $clog2(FRAME_W + 1);
    localparam int GAP_W   = $clog2(CS_GAP + 1);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    tx_state_e          state_q;
    logic [FRAME_W-1:0] shreg_q;
    logic [BIT_W-1:0]   bit_q;
    logic [GAP_W-1:0]   gap_q;
    logic               cs_q;
    logic               mosi_q;
    logic               fin_q;

    logic [FRAME_W-1:0] frame_s;
    logic               sclk_fall_s;
    logic               gap_end_s;
    logic               skip_s;
    logic               hold_s;

`ifdef MAX7219_TX_SKIP_REPEAT_EN
    logic               valid_q;
    logic               restart_q;
    logic [FRAME_W-1:0] last_q;

    assign skip_s = valid_q && ({address, data} == last_q);
    // A skipped frame re-enters the gap; the extra held cycle makes the
    // skip period CS_GAP+1 rather than CS_GAP.
    assign hold_s = restart_q;

    // Remember the last transmitted command and arm the one-cycle gap hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            restart_q <= 1'b0;
            last_q    <= '0;
        end else begin
            restart_q <= gap_end_s && skip_s;
            if (gap_end_s && !skip_s) begin
                valid_q <= 1'b1;
                last_q  <= {address, data};
            end
        end
    end
`else
    assign skip_s = 1'b0;
    assign hold_s = 1'b0;
`endif

    assign gap_end_s = (state_q == ST_GAP) && !hold_s && (gap_q == GAP_LAST);

    // Frame image: device SIZE-1 occupies the top word so it leaves first and
    // ends up travelling furthest down the chain.
    always_comb begin
        frame_s = '0;
        for (int k = 0; k < SIZE; k++) begin
            frame_s[WORD_W*k +: WORD_W] = make_word(address[8*k +: 8], data[8*k +: 8]);
        end
    end

    max7219_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk    (clk),
        .reset  (reset),
        .en_i   (state_q == ST_SHIFT),
        .sclk_o (sclk),
        .fall_o (sclk_fall_s)
    );

    // Transmit FSM with registered cs, mosi and finished.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_GAP;
            shreg_q <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_GAP: begin
                    bit_q <= '0;
                    if (gap_end_s) begin
                        gap_q <= '0;
                        if (skip_s) begin
                            fin_q <= 1'b1;
                        end else begin
                            shreg_q <= frame_s;
                            mosi_q  <= frame_s[FRAME_W-1];
                            cs_q    <= 1'b0;
                            fin_q   <= 1'b0;
                            state_q <= ST_SHIFT;
                        end
                    end else begin
                        fin_q <= 1'b0;
                        if (!hold_s) begin
                            gap_q <= gap_q + GAP_W'(1);
                        end
                    end
                end

                ST_SHIFT: begin
                    gap_q <= '0;
                    fin_q <= 1'b0;
                    if (sclk_fall_s) begin
                        if (bit_q == BIT_LAST) begin
                            cs_q    <= 1'b1;
                            fin_q   <= 1'b1;
                            mosi_q  <= 1'b0;
                            bit_q   <= '0;
                            state_q <= ST_GAP;
                        end else begin
                            shreg_q <= {shreg_q[FRAME_W-2:0], 1'b0};
                            mosi_q  <= shreg_q[FRAME_W-2];
                            bit_q   <= bit_q + BIT_W'(1);
                        end
                    end
                end

                default: begin
                    state_q <= ST_GAP;
                    gap_q   <= '0;
                    bit_q   <= '0;
                    cs_q    <= 1'b1;
                    mosi_q  <= 1'b0;
                    fin_q   <= 1'b0;
                end
            endcase
        end
    end

    assign cs       = cs_q;
    assign mosi     = mosi_q;
    assign finished = fin_q;

endmodule

// File: tb/tb_max7219_chain_tx.sv
// -----------------------------------------------------------------------------
// tb_max7219_chain_tx
// Self-checking bench for max7219_chain_tx (SIZE=2, CLK_DIV=2, CS_GAP=2).
// The expected serial word is built from the per-device address/data bytes
// with plain arithmetic; the bench samples outputs on the falling clk edge.
// -----------------------------------------------------------------------------
module tb_max7219_chain_tx;

    localparam int SIZE    = 2;
    localparam int CLK_DIV = 2;
    localparam int CS_GAP  = 2;
    localparam int NBITS   = 16 * SIZE;

    logic              clk;
    logic              reset;
    logic [8*SIZE-1:0] address;
    logic [8*SIZE-1:0] data;
    logic              mosi;
    logic              sclk;
    logic              cs;
    logic              finished;

    int n_assert = 0;
    int n_fail   = 0;

    max7219_chain_tx #(
        .SIZE    (SIZE),
        .CLK_DIV (CLK_DIV),
        .CS_GAP  (CS_GAP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .address  (address),
        .data     (data),
        .mosi     (mosi),
        .sclk     (sclk),
        .cs       (cs),
        .finished (finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: device SIZE-1 first, each word = address byte then data byte.
    function automatic logic [63:0] model_word(input logic [8*SIZE-1:0] a,
                                               input logic [8*SIZE-1:0] d);
        logic [63:0] w;
        w = 64'd0;
        for (int k = SIZE - 1; k >= 0; k--) begin
            w = w * 64'd65536 + 64'(a[8*k +: 8]) * 64'd256 + 64'(d[8*k +: 8]);
        end
        return w;
    endfunction

    // Sequencer reaction: one edge after finished is seen, present new command.
    task automatic seq_update(input logic [8*SIZE-1:0] a, input logic [8*SIZE-1:0] d);
        @(posedge clk);
        #1;
        address = a;
        data    = d;
    endtask

    // Waits for the next cs-low window, collects the bits seen on sclk rises
    // and checks frame shape. Optionally changes the inputs after bit chg_bit.
    task automatic capture(input string tag, input logic [63:0] exp_word, input int exp_gap,
                           input int chg_bit, input logic [8*SIZE-1:0] chg_a,
                           input logic [8*SIZE-1:0] chg_d);
        int          gap_cnt, gap_fin, nbits, nfin, cyc, first_rise;
        logic        prev;
        logic [63:0] w;
        gap_cnt = 0;
        gap_fin = 0;
        forever begin
            @(negedge clk);
            if (cs !== 1'b1 || gap_cnt > 1000) break;
            gap_cnt++;
            if (finished === 1'b1) gap_fin++;
        end
        if (exp_gap >= 0) begin
            chk({tag, "_gap_cycles"}, 64'(gap_cnt), 64'(exp_gap));
            chk({tag, "_gap_finished"}, 64'(gap_fin), 64'd0);
        end
        if (gap_cnt > 1000) begin
            chk({tag, "_cs_fall_timeout"}, 64'(cs), 64'd0);
            return;
        end
        w = 64'd0; nbits = 0; nfin = 0; cyc = 0; first_rise = -1; prev = 1'b0;
        while (cs === 1'b0 && cyc < 5000) begin
            if (sclk === 1'b1 && prev === 1'b0) begin
                w = {w[62:0], mosi};
                nbits++;
                if (first_rise < 0) first_rise = cyc;
                if (nbits == chg_bit) begin
                    address = chg_a;
                    data    = chg_d;
                end
            end
            if (finished === 1'b1) nfin++;
            prev = sclk;
            cyc++;
            @(negedge clk);
        end
        chk({tag, "_nbits"}, 64'(nbits), 64'(NBITS));
        chk({tag, "_word"}, w, exp_word);
        chk({tag, "_cs_low_cycles"}, 64'(cyc), 64'(32 * SIZE * CLK_DIV));
        chk({tag, "_first_rise"}, 64'(first_rise), 64'(CLK_DIV));
        chk({tag, "_fin_in_frame"}, 64'(nfin), 64'd0);
        chk({tag, "_fin_at_cs_rise"}, 64'(finished), 64'd1);
        chk({tag, "_sclk_end"}, 64'(sclk), 64'd0);
        chk({tag, "_mosi_end"}, 64'(mosi), 64'd0);
    endtask

    initial begin
        logic [8*SIZE-1:0] ra, rd;
        int                n, rises;
        logic              prev;

        reset   = 1'b1;
        address = {8'h0B, 8'h0B};
        data    = {8'h07, 8'h07};
        repeat (3) @(negedge clk);
        chk("rst_cs", 64'(cs), 64'd1);
        chk("rst_sclk", 64'(sclk), 64'd0);
        chk("rst_mosi", 64'(mosi), 64'd0);
        chk("rst_finished", 64'(finished), 64'd0);
        reset = 1'b0;

        // First frame: cs falls on the CS_GAP-th edge after release.
        capture("f1", model_word(address, data), CS_GAP - 1, 0, '0, '0);

`ifndef MAX7219_TX_SKIP_REPEAT_EN
        // Unchanged inputs: transmission continues back-to-back.
        capture("f2", model_word(address, data), CS_GAP - 1, 0, '0, '0);
        n = CS_GAP - 1;
`else
        // Repeated command is suppressed: no cs fall, finished every CS_GAP+1.
        begin
            int lows, pulses, bad_phase;
            lows = 0; pulses = 0; bad_phase = 0;
            for (int i = 1; i <= 15; i++) begin
                @(negedge clk);
                if (cs !== 1'b1) lows++;
                if (finished === 1'b1) begin
                    pulses++;
                    if ((i % (CS_GAP + 1)) != CS_GAP) bad_phase++;
                end
            end
            chk("skip_cs_lows", 64'(lows), 64'd0);
            chk("skip_pulses", 64'(pulses), 64'd5);
            chk("skip_pulse_phase", 64'(bad_phase), 64'd0);
        end
        n = -1;
`endif

        // Device 1 word first; a mid-frame input change must not leak in.
        seq_update({8'h01, 8'h02}, {8'hAA, 8'h55});
        ra = 16'($urandom);
        rd = 16'($urandom);
        capture("f3", 64'h01AA_0255, n, 5, ra, rd);
        seq_update({8'h03, 8'h03}, {8'hF0, 8'h0F});
        capture("f4", 64'h03F0_030F, CS_GAP - 1, 0, '0, '0);

        // Random commands presented by the sequencer model.
        for (int i = 0; i < 3; i++) begin
            ra = 16'($urandom);
            rd = 16'($urandom);
            seq_update(ra, rd);
            capture($sformatf("rnd%0d", i), model_word(ra, rd), CS_GAP - 1, 0, '0, '0);
        end

        // Reset in the middle of a frame, after the 10th sclk rise.
        ra = 16'($urandom);
        rd = 16'($urandom);
        seq_update(ra, rd);
        n = 0;
        while (cs !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("mid_cs_fall", 64'(cs), 64'd0);
        rises = 0; prev = 1'b0; n = 0;
        while (rises < 10 && n < 2000) begin
            @(negedge clk);
            if (sclk === 1'b1 && prev === 1'b0) rises++;
            prev = sclk;
            n++;
        end
        chk("mid_rises", 64'(rises), 64'd10);
        chk("mid_sclk_high", 64'(sclk), 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_cs", 64'(cs), 64'd1);
        chk("mid_rst_sclk", 64'(sclk), 64'd0);
        chk("mid_rst_fin", 64'(finished), 64'd0);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (finished !== 1'b0) n++;
        end
        chk("mid_rst_no_fin", 64'(n), 64'd0);
        reset = 1'b0;
        capture("restart", model_word(ra, rd), CS_GAP - 1, 0, '0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
